// File: rtl/core_pkg.sv
// Shared core definitions: fetch constants, the IF/ID register layout reused by
// the decode stage, and a word-alignment helper for PC redirects.
package core_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'hE1A0_0000;  // MOV R0,R0
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          IMEM_WORDS = 64;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus8;
        logic        valid;
        logic        fault;
    } ifid_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: next-PC select (redirects over stall over increment) and the
// PC flop. The output is a pure register, with no input-to-output path.
module pc_reg #(
    parameter logic [31:0] RESET_PC = core_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stall,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_pc_wr,
    input  logic [31:0] i_pc_wr_val,
    output logic [31:0] o_pc
);
    import core_pkg::*;

    logic [31:0] r_pc;

    // A redirect beats StallF so a taken branch survives a load-use stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (i_br_taken) begin
            r_pc <= word_align(i_br_target);
        end else if (i_pc_wr) begin
            r_pc <= word_align(i_pc_wr_val);
        end else if (!i_stall) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, captures imem data into the IF/ID register, flags
// out-of-range fetches and counts instructions accepted into Decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = core_pkg::RESET_PC,
    parameter int          IMEM_WORDS = core_pkg::IMEM_WORDS,
    parameter logic [31:0] NOP_INSTR  = core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic [31:0] PCF,
    input  logic [31:0] InstrF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD,
    output logic        FaultD,
    output logic [31:0] FetchCount
);
    import core_pkg::*;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    ifid_t       r_ifid;
    logic [31:0] r_fetch_cnt;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus8;
    logic        w_oor;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .i_stall     (StallF),
        .i_br_taken  (BranchTakenE),
        .i_br_target (BranchTargetE),
        .i_pc_wr     (PCSrcW),
        .i_pc_wr_val (ResultW),
        .o_pc        (w_pc)
    );

    assign w_pc_plus8 = w_pc + 32'd8;
    assign w_oor      = {2'b00, w_pc[31:2]} >= IMEM_LIMIT;

    // IF/ID register: flush over stall over load; imem data is ignored out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ifid      <= '{instr: NOP_INSTR, pc_plus8: RESET_PC + 32'd8, valid: 1'b0, fault: 1'b0};
            r_fetch_cnt <= '0;
        end else if (FlushD) begin
            r_ifid <= '{instr: NOP_INSTR, pc_plus8: w_pc_plus8, valid: 1'b0, fault: 1'b0};
        end else if (!StallD) begin
            if (w_oor) begin
                r_ifid <= '{instr: NOP_INSTR, pc_plus8: w_pc_plus8, valid: 1'b0, fault: 1'b1};
            end else begin
                r_ifid      <= '{instr: InstrF, pc_plus8: w_pc_plus8, valid: 1'b1, fault: 1'b0};
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
        end
    end

    assign PCF        = w_pc;
    assign InstrD     = r_ifid.instr;
    assign PCPlus8D   = r_ifid.pc_plus8;
    assign ValidD     = r_ifid.valid;
    assign FaultD     = r_ifid.fault;
    assign FetchCount = r_fetch_cnt;

endmodule
